// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/ertn sequencer between WB and the CSR file.
// Picks the highest-priority cause on the retiring instruction, then issues a
// one-cycle CSR commit pulse, a FLUSH_LEN-cycle pipeline flush and a fetch
// redirect to EENTRY (exception/interrupt) or ERA (ertn).
module exc_ctrl #(
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc_in,
    input  logic [5:0]  wb_exc_vec,
    input  logic        wb_is_ertn,
    input  logic        wb_csr_we,
    input  logic        int_pending,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_pc,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wb_commit,
    output logic        csr_we_ok,
    output logic        wb_allow
);

    localparam int unsigned CNT_W = 3;
    // Remaining FLUSH-state cycles after the first one, loaded in COMMIT.
    localparam logic [CNT_W-1:0] CNT_INIT =
        (FLUSH_LEN > 1) ? CNT_W'(FLUSH_LEN - 2) : '0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_exc;
    logic [31:0]      r_pc;
    logic [5:0]       r_ecode;
    logic [8:0]       r_esub;

    logic             w_exc_int;
    logic             w_trigger;
    logic [5:0]       w_ecode;
    logic [8:0]       w_esub;

    assign w_exc_int = int_pending | (|wb_exc_vec);
    assign w_trigger = wb_valid & (w_exc_int | wb_is_ertn);

    // Cause priority encoder: INT > ADEF > INE > SYS > BRK > ALE > ADEM.
    always_comb begin
        w_ecode = 6'h00;
        w_esub  = 9'd0;
        if (int_pending) begin
            w_ecode = ECODE_INT;
        end else if (wb_exc_vec[0]) begin
            w_ecode = ECODE_ADE;
        end else if (wb_exc_vec[1]) begin
            w_ecode = ECODE_INE;
        end else if (wb_exc_vec[2]) begin
            w_ecode = ECODE_SYS;
        end else if (wb_exc_vec[3]) begin
            w_ecode = ECODE_BRK;
        end else if (wb_exc_vec[4]) begin
            w_ecode = ECODE_ALE;
        end else if (wb_exc_vec[5]) begin
            w_ecode = ECODE_ADE;
            w_esub  = 9'd1;
        end
    end

    // State, flush counter and latched fault information.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_exc <= 1'b0;
            r_pc     <= '0;
            r_ecode  <= '0;
            r_esub   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_trigger) begin
                r_pc     <= wb_pc_in;
                r_ecode  <= w_ecode;
                r_esub   <= w_esub;
                r_is_exc <= w_exc_int;
            end
            if (r_state == S_COMMIT) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == S_FLUSH && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next         = r_state;
        wb_ex          = 1'b0;
        ertn_flush     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        wb_commit      = 1'b0;
        csr_we_ok      = 1'b0;
        wb_allow       = 1'b0;
        case (r_state)
            S_IDLE: begin
                wb_allow  = 1'b1;
                wb_commit = wb_valid & ~w_exc_int;
                csr_we_ok = wb_valid & wb_csr_we & ~w_exc_int;
                if (w_trigger) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                wb_ex          = r_is_exc;
                ertn_flush     = ~r_is_exc;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_is_exc ? csr_eentry : csr_era;
                w_next         = (FLUSH_LEN > 1) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign wb_pc       = r_pc;
    assign wb_ecode    = r_ecode;
    assign wb_esubcode = r_esub;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed testbench for exc_ctrl: vector table plus hand-written sequences.
module tb_exc_ctrl;

    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_0204;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc_in;
    logic [5:0]  wb_exc_vec;
    logic        wb_is_ertn;
    logic        wb_csr_we;
    logic        int_pending;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;

    logic        wb_ex, ertn_flush, flush, redirect_valid, wb_commit, csr_we_ok, wb_allow;
    logic [31:0] wb_pc, redirect_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;

    logic        wb_ex1, ertn_flush1, flush1, redirect_valid1, wb_commit1, csr_we_ok1, wb_allow1;
    logic [31:0] wb_pc1, redirect_pc1;
    logic [5:0]  wb_ecode1;
    logic [8:0]  wb_esubcode1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.FLUSH_LEN(2)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
        .wb_exc_vec(wb_exc_vec), .wb_is_ertn(wb_is_ertn), .wb_csr_we(wb_csr_we),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .wb_commit(wb_commit), .csr_we_ok(csr_we_ok),
        .wb_allow(wb_allow)
    );

    exc_ctrl #(.FLUSH_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
        .wb_exc_vec(wb_exc_vec), .wb_is_ertn(wb_is_ertn), .wb_csr_we(wb_csr_we),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex1), .ertn_flush(ertn_flush1), .wb_pc(wb_pc1), .wb_ecode(wb_ecode1),
        .wb_esubcode(wb_esubcode1), .flush(flush1), .redirect_valid(redirect_valid1),
        .redirect_pc(redirect_pc1), .wb_commit(wb_commit1), .csr_we_ok(csr_we_ok1),
        .wb_allow(wb_allow1)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  exc;
        logic        ertn;
        logic        csr_we;
        logic        intp;
        logic        e_commit;
        logic        e_we_ok;
        logic        e_trig;
        logic        e_exc;
        logic        chk_code;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid    = 1'b0;
        wb_pc_in    = '0;
        wb_exc_vec  = '0;
        wb_is_ertn  = 1'b0;
        wb_csr_we   = 1'b0;
        int_pending = 1'b0;
    endtask

    // Count flush-high cycles from the current sample point (bounded).
    task automatic count_flush(output int n);
        n = 0;
        while (flush && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        int nf;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        wb_valid    = v.valid;
        wb_pc_in    = v.pc;
        wb_exc_vec  = v.exc;
        wb_is_ertn  = v.ertn;
        wb_csr_we   = v.csr_we;
        int_pending = v.intp;
        #1;
        chk({tag, ".wb_commit"}, 32'(wb_commit), 32'(v.e_commit));
        chk({tag, ".csr_we_ok"}, 32'(csr_we_ok), 32'(v.e_we_ok));
        @(negedge clk);
        idle_inputs();
        #1;
        if (v.e_trig) begin
            chk({tag, ".wb_ex"}, 32'(wb_ex), 32'(v.e_exc));
            chk({tag, ".ertn_flush"}, 32'(ertn_flush), 32'(!v.e_exc));
            chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd1);
            chk({tag, ".redirect_pc"}, redirect_pc, v.e_exc ? EENTRY : ERA);
            chk({tag, ".wb_pc"}, wb_pc, v.pc);
            chk({tag, ".wb_allow"}, 32'(wb_allow), 32'd0);
            count_flush(nf);
            chk({tag, ".flush_cycles"}, 32'(nf), 32'd2);
            chk({tag, ".wb_allow_after"}, 32'(wb_allow), 32'd1);
        end else begin
            chk({tag, ".wb_ex"}, 32'(wb_ex), 32'd0);
            chk({tag, ".flush"}, 32'(flush), 32'd0);
            chk({tag, ".wb_allow"}, 32'(wb_allow), 32'd1);
        end
        if (v.chk_code) begin
            chk({tag, ".wb_ecode"}, 32'(wb_ecode), 32'(v.e_ecode));
            chk({tag, ".wb_esubcode"}, 32'(wb_esubcode), 32'(v.e_esub));
        end
    endtask

    initial begin
        int nf;
        vec_t v;
        //          valid pc             exc        ertn we  int  commit weok trig exc  chkc ecode  esub
        vecs[0]  = '{1'b1, 32'h1C00_0100, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0B, 9'd0};
        vecs[1]  = '{1'b1, 32'h1C00_0110, 6'b100011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 9'd0};
        vecs[2]  = '{1'b1, 32'h1C00_0120, 6'b100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h08, 9'd0};
        vecs[3]  = '{1'b1, 32'h1C00_0130, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h08, 9'd1};
        vecs[4]  = '{1'b1, 32'h1C00_0140, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 9'd0};
        vecs[5]  = '{1'b1, 32'h1C00_0150, 6'b000010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0D, 9'd0};
        vecs[6]  = '{1'b1, 32'h1C00_0160, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h0D, 9'd0};
        vecs[7]  = '{1'b1, 32'h1C00_0170, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0C, 9'd0};
        vecs[8]  = '{1'b1, 32'h1C00_0180, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h09, 9'd0};
        vecs[9]  = '{1'b1, 32'h1C00_0190, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h00, 9'd0};
        vecs[10] = '{1'b1, 32'h1C00_01A0, 6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h08, 9'd0};
        vecs[11] = '{1'b0, 32'h1C00_01B0, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h08, 9'd0};
        vecs[12] = '{1'b1, 32'h1C00_01C0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h08, 9'd0};

        csr_eentry = EENTRY;
        csr_era    = ERA;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.wb_ex", 32'(wb_ex), 32'd0);
        chk("rst.ertn_flush", 32'(ertn_flush), 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        chk("rst.wb_pc", wb_pc, 32'd0);
        chk("rst.wb_ecode", 32'(wb_ecode), 32'd0);
        chk("rst.wb_esubcode", 32'(wb_esubcode), 32'd0);
        chk("rst.wb_allow", 32'(wb_allow), 32'd1);
        chk("rst.wb_allow1", 32'(wb_allow1), 32'd1);

        for (int i = 0; i < 13; i++) begin
            apply(i, vecs[i]);
        end

        // Triggers on consecutive cycles; second instance has FLUSH_LEN=1.
        @(negedge clk);
        wb_valid = 1'b1; wb_exc_vec = 6'b000100; wb_pc_in = 32'h1C00_0A00;
        @(negedge clk);
        wb_exc_vec = 6'b000000; wb_csr_we = 1'b1; wb_pc_in = 32'h1C00_0A04;
        #1;
        chk("b2b.commit_wb_ex", 32'(wb_ex), 32'd1);
        chk("b2b.commit_allow", 32'(wb_allow), 32'd0);
        chk("b2b.commit_wb_commit", 32'(wb_commit), 32'd0);
        chk("b2b.commit_csr_we_ok", 32'(csr_we_ok), 32'd0);
        chk("b2b.fl1_flush", 32'(flush1), 32'd1);
        @(negedge clk);
        wb_exc_vec = 6'b001000; wb_csr_we = 1'b0; wb_pc_in = 32'h1C00_0A08;
        #1;
        chk("b2b.flush_state_flush", 32'(flush), 32'd1);
        chk("b2b.flush_state_wb_ex", 32'(wb_ex), 32'd0);
        chk("b2b.flush_state_allow", 32'(wb_allow), 32'd0);
        chk("b2b.flush_state_wb_pc", wb_pc, 32'h1C00_0A00);
        chk("b2b.fl1_flush_off", 32'(flush1), 32'd0);
        chk("b2b.fl1_allow", 32'(wb_allow1), 32'd1);
        @(negedge clk);
        #1;
        chk("b2b.idle_allow", 32'(wb_allow), 32'd1);
        chk("b2b.idle_flush", 32'(flush), 32'd0);
        chk("b2b.ignored_ecode", 32'(wb_ecode), 32'h0B);
        chk("b2b.idle_wb_commit", 32'(wb_commit), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("b2b.second_wb_ex", 32'(wb_ex), 32'd1);
        chk("b2b.second_ecode", 32'(wb_ecode), 32'h0C);
        chk("b2b.second_wb_pc", wb_pc, 32'h1C00_0A08);
        count_flush(nf);
        chk("b2b.second_flush_cycles", 32'(nf), 32'd2);
        repeat (3) @(negedge clk);

        // Reset asserted during the FLUSH cycle.
        wb_valid = 1'b1; wb_exc_vec = 6'b000100; wb_pc_in = 32'h1C00_0B00;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("rstfl.in_flush", 32'(flush), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstfl.flush", 32'(flush), 32'd0);
        chk("rstfl.wb_allow", 32'(wb_allow), 32'd1);
        chk("rstfl.wb_ex", 32'(wb_ex), 32'd0);
        chk("rstfl.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rstfl.wb_pc", wb_pc, 32'd0);
        chk("rstfl.wb_ecode", 32'(wb_ecode), 32'd0);
        @(negedge clk);
        #1;
        chk("rstfl.no_repeat_pulse", 32'(wb_ex), 32'd0);
        v = '{1'b1, 32'h1C00_0C00, 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0C, 9'd0};
        apply(99, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/ertn sequencer between the WB stage and the CSR file; sole driver of the CSR module's wb_ex, ertn_flush, wb_pc, wb_ecode and wb_esubcode inputs.
- Prioritises exception causes and pending interrupts on the retiring instruction.
- Sequences a single-cycle CSR commit pulse, a multi-cycle pipeline flush and a fetch redirect to EENTRY or ERA.
- Gates WB-stage CSR writes and regfile commit so that a faulting instruction has no architectural side effects.

Parameters:
FLUSH_LEN, 2, cycles the flush output is held (1..7), starting with the commit cycle.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  WB stage holds a valid instruction this cycle
wb_pc_in  in  32  PC of WB instruction
wb_exc_vec  in  6  cause flags: [0]ADEF [1]INE [2]SYS [3]BRK [4]ALE [5]ADEM
wb_is_ertn  in  1  WB instruction is ertn
wb_csr_we  in  1  WB instruction requests CSR write
int_pending  in  1  enabled interrupt pending (computed outside, already ANDed with CRMD.IE)
csr_eentry  in  32  EENTRY value from CSR file
csr_era  in  32  ERA value from CSR file
wb_ex  out  1  one-cycle exception commit pulse to CSR file
ertn_flush  out  1  one-cycle ertn commit pulse to CSR file
wb_pc  out  32  latched faulting PC to CSR file
wb_ecode  out  6  latched Ecode
wb_esubcode  out  9  latched EsubCode
flush  out  1  kill all pipeline stages
redirect_valid  out  1  one-cycle fetch redirect strobe
redirect_pc  out  32  redirect target
wb_commit  out  1  WB instruction may write regfile
csr_we_ok  out  1  gated CSR write enable
wb_allow  out  1  WB may accept a new instruction

Behaviour:
- Reset: state IDLE; every output 0, except wb_allow=1. Latched pc/ecode/esubcode = 0.
- Trigger event in IDLE: wb_valid & (int_pending | |wb_exc_vec | wb_is_ertn).
- Cause priority, highest first, with code mapping:
  - INT: ecode 0x00, esub 0.
  - ADEF: 0x08, esub 0.
  - INE: 0x0D.
  - SYS: 0x0B.
  - BRK: 0x0C.
  - ALE: 0x09.
  - ADEM: 0x08, esub 1.
  - All esub values not listed are 0.
- Any exception or interrupt beats ertn. An ertn carrying an exception is treated as that exception only.
- Combinational gating, asserted only in IDLE and only when no exception/interrupt is present:
  - wb_commit = wb_valid & ~exc & ~int.
  - csr_we_ok = wb_valid & wb_csr_we & ~exc & ~int.
  - ertn alone still gives wb_commit=1.
- FSM states:
  - IDLE → COMMIT on trigger at cycle T. At T the block latches wb_pc_in, ecode, esub and kind (EXC/ERTN).
  - COMMIT (T+1):
    - wb_ex=1 (EXC) or ertn_flush=1 (ERTN), one cycle only.
    - flush=1.
    - redirect_valid=1.
    - redirect_pc = csr_eentry (EXC) or csr_era (ERTN), sampled combinationally this cycle.
    - Next state: FLUSH if FLUSH_LEN>1, else IDLE.
  - FLUSH: flush=1 and a down-counter runs. Returns to IDLE after flush has been high FLUSH_LEN cycles total.
- wb_allow=0 in COMMIT and FLUSH.
- wb_valid and all causes are ignored outside IDLE; wb_commit=csr_we_ok=0 there.
- wb_pc/wb_ecode/wb_esubcode hold their latched values until the next trigger.
- Back-to-back: a trigger in the first IDLE cycle after FLUSH is accepted normally.
- Reset mid-COMMIT/FLUSH: next cycle IDLE with all outputs at reset values. No partial pulse is repeated.
- int_pending without wb_valid: no action. Interrupts are taken only on a valid retiring instruction, which is then not committed.

Test Plan:
- wb_valid=1, wb_pc_in=0x1C000100, wb_exc_vec=6'b000100 (SYS), eentry=0x1C008000 → T+1: wb_ex=1, ecode 0x0B, wb_pc 0x1C000100, redirect_pc 0x1C008000; flush high exactly 2 cycles; wb_commit=0 at T.
- wb_exc_vec=6'b100011 with int_pending=1 → ecode 0x00; with int_pending=0 → ecode 0x08, esub 0; with only bit5 → ecode 0x08, esub 1.
- wb_is_ertn=1, csr_era=0x1C000204, no causes → T+1: ertn_flush=1, wb_ex=0, redirect_pc 0x1C000204, wb_commit=1 at T.
- wb_csr_we=1 with INE set → csr_we_ok=0; same instruction with no cause → csr_we_ok=1, no state change.
- Triggers on consecutive cycles → second ignored during COMMIT/FLUSH; wb_allow=0 for FLUSH_LEN cycles; with FLUSH_LEN=1, flush high 1 cycle only.
- Reset asserted in the FLUSH cycle → next cycle flush=0, wb_allow=1, state IDLE; a fresh BRK then yields ecode 0x0C.
